// File: rtl/regfile_2r1w.sv
// regfile_2r1w: DEPTH x WIDTH register file with one write port and two
// independent registered read ports (A and B). Reads have one cycle of latency,
// and a write to the same address in the same cycle is bypassed to the read
// ("write-first"). When ZERO_REG is 1, register 0 always reads as zero.
//
// Read interface: re_x is a request with no back-pressure, so there is no
// ready signal. rvalid_x is high for exactly the cycle after each accepted
// request. rdata_x is valid only while rvalid_x is high. Otherwise rdata_x
// keeps the last value it returned. Reset drops any request made in its cycle.
module regfile_2r1w #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re_a,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [WIDTH-1:0]  rdata_a,
  output logic              rvalid_a,
  input  logic              re_b,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_b,
  output logic              rvalid_b
);

  localparam logic ZERO_EN = (ZERO_REG != 0);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] next_a;
  logic [WIDTH-1:0] next_b;
  logic             wr_en;

  // A write to register 0 is discarded while that register is hardwired to zero.
  always_comb begin
    wr_en = we;
    if (ZERO_EN && (waddr == '0)) wr_en = 1'b0;
  end

  // Storage update. Reset clears every entry and takes priority over the write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[waddr] <= wdata;
    end
  end

  // Port A read word. Bypass takes priority over the array, and the zero
  // register overrides both.
  always_comb begin
    next_a = mem[raddr_a];
    if (we && (waddr == raddr_a)) next_a = wdata;
    if (ZERO_EN && (raddr_a == '0)) next_a = '0;
  end

  // Port B read word, with the same priority as port A.
  always_comb begin
    next_b = mem[raddr_b];
    if (we && (waddr == raddr_b)) next_b = wdata;
    if (ZERO_EN && (raddr_b == '0)) next_b = '0;
  end

  // Port A output register. Data is held when no request is made.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_a  <= '0;
      rvalid_a <= 1'b0;
    end else begin
      rvalid_a <= re_a;
      if (re_a) rdata_a <= next_a;
    end
  end

  // Port B output register. Data is held when no request is made.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_b  <= '0;
      rvalid_b <= 1'b0;
    end else begin
      rvalid_b <= re_b;
      if (re_b) rdata_b <= next_b;
    end
  end

endmodule

// File: tb/tb_regfile_2r1w.sv
// tb_regfile_2r1w: scoreboard bench for regfile_2r1w. It uses one instance with
// the default parameters (32x32, zero register) and one small instance
// (8-bit x 4, no zero register).
module tb_regfile_2r1w;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- default instance ----------------
  logic        reset32 = 1'b0, we32 = 1'b0, re_a32 = 1'b0, re_b32 = 1'b0;
  logic [4:0]  waddr32 = '0, raddr_a32 = '0, raddr_b32 = '0;
  logic [31:0] wdata32 = '0;
  logic [31:0] rdata_a32, rdata_b32;
  logic        rvalid_a32, rvalid_b32;

  regfile_2r1w u_dut32 (
    .clk(clk), .reset(reset32), .we(we32), .waddr(waddr32), .wdata(wdata32),
    .re_a(re_a32), .raddr_a(raddr_a32), .rdata_a(rdata_a32), .rvalid_a(rvalid_a32),
    .re_b(re_b32), .raddr_b(raddr_b32), .rdata_b(rdata_b32), .rvalid_b(rvalid_b32)
  );

  // ---------------- small instance ----------------
  logic        reset8 = 1'b0, we8 = 1'b0, re_a8 = 1'b0, re_b8 = 1'b0;
  logic [1:0]  waddr8 = '0, raddr_a8 = '0, raddr_b8 = '0;
  logic [7:0]  wdata8 = '0;
  logic [7:0]  rdata_a8, rdata_b8;
  logic        rvalid_a8, rvalid_b8;

  regfile_2r1w #(.WIDTH(8), .DEPTH(4), .ADDR_W(2), .ZERO_REG(0)) u_dut8 (
    .clk(clk), .reset(reset8), .we(we8), .waddr(waddr8), .wdata(wdata8),
    .re_a(re_a8), .raddr_a(raddr_a8), .rdata_a(rdata_a8), .rvalid_a(rvalid_a8),
    .re_b(re_b8), .raddr_b(raddr_b8), .rdata_b(rdata_b8), .rvalid_b(rvalid_b8)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  logic [31:0] exp_a32_q[$];
  logic [31:0] exp_b32_q[$];
  logic [7:0]  exp_a8_q[$];
  logic [7:0]  exp_b8_q[$];

  logic [31:0] mem32 [32];
  logic [7:0]  mem8  [4];
  logic [31:0] last_a32 = '0, last_b32 = '0;
  logic [7:0]  last_a8 = '0, last_b8 = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rd32(input logic [4:0] a, input logic w,
                                       input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'h0;
    if (w && (wa == a)) return wd;
    return mem32[a];
  endfunction

  function automatic logic [7:0] rd8(input logic [1:0] a, input logic w,
                                     input logic [1:0] wa, input logic [7:0] wd);
    if (w && (wa == a)) return wd;
    return mem8[a];
  endfunction

  // ---------------- driver tasks ----------------
  // Drive one cycle on the default instance, then check its outputs 1ns after the edge.
  task automatic step32(input logic rst, input logic w, input logic [4:0] wa,
                        input logic [31:0] wd, input logic ea, input logic [4:0] ra,
                        input logic eb, input logic [4:0] rb);
    logic [31:0] e;
    reset32 = rst; we32 = w; waddr32 = wa; wdata32 = wd;
    re_a32 = ea; raddr_a32 = ra; re_b32 = eb; raddr_b32 = rb;
    if (rst) begin
      for (int i = 0; i < 32; i++) mem32[i] = '0;
      last_a32 = '0; last_b32 = '0;
    end else begin
      if (ea) begin e = rd32(ra, w, wa, wd); exp_a32_q.push_back(e); last_a32 = e; end
      if (eb) begin e = rd32(rb, w, wa, wd); exp_b32_q.push_back(e); last_b32 = e; end
      if (w && (wa != 5'd0)) mem32[wa] = wd;
    end
    @(posedge clk); #1;
    chk("rvalid_a32", 64'(rvalid_a32), 64'(!rst && ea));
    chk("rvalid_b32", 64'(rvalid_b32), 64'(!rst && eb));
    if (!rst && ea) chk("rdata_a32", 64'(rdata_a32), 64'(exp_a32_q.pop_front()));
    else            chk("hold_a32", 64'(rdata_a32), 64'(last_a32));
    if (!rst && eb) chk("rdata_b32", 64'(rdata_b32), 64'(exp_b32_q.pop_front()));
    else            chk("hold_b32", 64'(rdata_b32), 64'(last_b32));
  endtask

  // Drive one cycle on the small instance, then check its outputs 1ns after the edge.
  task automatic step8(input logic rst, input logic w, input logic [1:0] wa,
                       input logic [7:0] wd, input logic ea, input logic [1:0] ra,
                       input logic eb, input logic [1:0] rb);
    logic [7:0] e;
    reset8 = rst; we8 = w; waddr8 = wa; wdata8 = wd;
    re_a8 = ea; raddr_a8 = ra; re_b8 = eb; raddr_b8 = rb;
    if (rst) begin
      for (int i = 0; i < 4; i++) mem8[i] = '0;
      last_a8 = '0; last_b8 = '0;
    end else begin
      if (ea) begin e = rd8(ra, w, wa, wd); exp_a8_q.push_back(e); last_a8 = e; end
      if (eb) begin e = rd8(rb, w, wa, wd); exp_b8_q.push_back(e); last_b8 = e; end
      if (w) mem8[wa] = wd;
    end
    @(posedge clk); #1;
    chk("rvalid_a8", 64'(rvalid_a8), 64'(!rst && ea));
    chk("rvalid_b8", 64'(rvalid_b8), 64'(!rst && eb));
    if (!rst && ea) chk("rdata_a8", 64'(rdata_a8), 64'(exp_a8_q.pop_front()));
    else            chk("hold_a8", 64'(rdata_a8), 64'(last_a8));
    if (!rst && eb) chk("rdata_b8", 64'(rdata_b8), 64'(exp_b8_q.pop_front()));
    else            chk("hold_b8", 64'(rdata_b8), 64'(last_b8));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Default instance: reset, then the directed cases.
    step32(1, 0, 0, 0, 0, 0, 0, 0);
    step32(1, 0, 0, 0, 0, 0, 0, 0);
    step32(0, 0, 0, 0, 1, 5'd7, 0, 0);                      // read after reset -> 0
    step32(0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0);           // write
    step32(0, 0, 0, 0, 0, 0, 1, 5'd5);                      // read back on B
    step32(0, 1, 5'd9, 32'h1, 0, 0, 0, 0);
    step32(0, 1, 5'd9, 32'h12345678, 1, 5'd9, 1, 5'd9);     // bypass, both ports
    step32(0, 1, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 0, 0);        // zero reg, no bypass
    step32(0, 0, 0, 0, 1, 5'd0, 1, 5'd0);                   // zero reg read on both ports
    step32(0, 0, 0, 0, 0, 0, 0, 0);                         // idle: data held
    step32(0, 1, 5'd3, 32'h0BADF00D, 1, 5'd5, 1, 5'd5);     // same address on both ports
    step32(1, 1, 5'd3, 32'hA5A5A5A5, 1, 5'd3, 1, 5'd9);     // reset wins
    step32(0, 0, 0, 0, 1, 5'd3, 1, 5'd5);                   // cleared by reset
    step32(0, 1, 5'd31, 32'hCAFE0031, 0, 0, 0, 0);          // top address
    step32(0, 0, 0, 0, 1, 5'd31, 1, 5'd30);
    for (int n = 0; n < 300; n++) begin
      step32(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 31)), 32'($urandom),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
    end
    step32(0, 0, 0, 0, 0, 0, 0, 0);

    // Small instance: address 0 is ordinary storage.
    step8(1, 0, 0, 0, 0, 0, 0, 0);
    step8(0, 0, 0, 0, 1, 2'd0, 1, 2'd3);
    for (int i = 0; i < 4; i++) step8(0, 1, 2'(i), 8'(8'h10 + i), 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step8(0, 0, 0, 0, 1, 2'(i), 1, 2'(3 - i));
    step8(0, 1, 2'd0, 8'h77, 1, 2'd0, 1, 2'd1);             // bypass on address 0
    for (int n = 0; n < 100; n++) begin
      step8(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    end

    // ---------------- final report ----------------
    chk("queue_empty", 64'(exp_a32_q.size() + exp_b32_q.size() +
                           exp_a8_q.size() + exp_b8_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
